// File: rtl/mac_sequencer.sv
// Sequences one dot product through an external 8-bit MAC core with a two-stage pipeline:
// it fetches operand pairs, times the clear/output-enable strobes and holds the result for a valid/ready consumer.
module mac_sequencer #(
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [7:0]        w_data,
  input  logic [7:0]        x_data,
  output logic [7:0]        mac_weight,
  output logic [7:0]        mac_in,
  output logic              mac_forget,
  output logic              mac_oe,
  input  logic [7:0]        mac_out,
  output logic [7:0]        result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CAPTURE, HOLD} state_t;

  state_t             state_reg;
  logic [LEN_W:0]     t_reg;
  logic [LEN_W:0]     t_inc;
  logic [LEN_W:0]     le;
  logic [LEN_W-1:0]   len_reg;
  logic               rd_valid_reg;

  // An empty dot product still walks one RUN cycle so the forget/oe spacing stays fixed.
  assign le    = (len_reg == '0) ? (LEN_W+1)'(1) : {1'b0, len_reg};
  assign t_inc = t_reg + 1'b1;

  // Memory data is only meaningful the cycle after a read; otherwise feed zeros so the sum is untouched.
  assign mac_weight = rd_valid_reg ? w_data : 8'd0;
  assign mac_in     = rd_valid_reg ? x_data : 8'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      t_reg        <= '0;
      len_reg      <= '0;
      rd_valid_reg <= 1'b0;
      rd_en        <= 1'b0;
      w_addr       <= '0;
      x_addr       <= '0;
      mac_forget   <= 1'b0;
      mac_oe       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      rd_en        <= 1'b0;
      mac_forget   <= 1'b0;
      mac_oe       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg   <= len;
            t_reg     <= '0;
            rd_en     <= (len != '0);
            w_addr    <= w_base;
            x_addr    <= x_base;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          t_reg      <= t_inc;
          mac_forget <= (t_reg == (LEN_W+1)'(1));
          if (t_inc < {1'b0, len_reg}) begin
            rd_en  <= 1'b1;
            w_addr <= w_addr + 1'b1;
            x_addr <= x_addr + 1'b1;
          end
          if (t_inc == le) state_reg <= DRAIN;
        end
        DRAIN: begin
          t_reg      <= t_inc;
          mac_forget <= (t_reg == (LEN_W+1)'(1));
          // Last product lands in the accumulator at t=Le+1, so enable the output one cycle later.
          if (t_reg == le + 1'b1) begin
            mac_oe    <= 1'b1;
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          result       <= mac_out;
          result_valid <= 1'b1;
          state_reg    <= HOLD;
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench: memories and a two-stage MAC core model around mac_sequencer, checking
// results, strobe timing, latency, address wrap, back-pressure and mid-run reset.
module tb_mac_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic [5:0] w_base, x_base;
  logic       rd_en;
  logic [5:0] w_addr, x_addr;
  logic [7:0] w_data, x_data;
  logic [7:0] mac_weight, mac_in;
  logic       mac_forget, mac_oe;
  logic [7:0] mac_out;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       busy;

  logic [7:0] w_mem [0:63];
  logic [7:0] x_mem [0:63];
  logic [7:0] prod_reg, acc_reg;
  logic [15:0] prod_full;

  int check_count = 0;
  int pass_count  = 0;
  int addr_log [0:3];
  int x_first;

  always #5 clk = ~clk;

  mac_sequencer #(.ADDR_W(6), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .w_base(w_base), .x_base(x_base), .rd_en(rd_en),
    .w_addr(w_addr), .x_addr(x_addr), .w_data(w_data), .x_data(x_data),
    .mac_weight(mac_weight), .mac_in(mac_in), .mac_forget(mac_forget),
    .mac_oe(mac_oe), .mac_out(mac_out), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
  );

  // Synchronous-read memories
  always @(posedge clk) begin
    if (rd_en) begin
      w_data <= w_mem[w_addr];
      x_data <= x_mem[x_addr];
    end
  end

  // Core model: product register, then accumulate or reload on forget
  assign prod_full = mac_weight * mac_in;
  assign mac_out   = mac_oe ? acc_reg : 8'd0;
  always @(posedge clk) begin
    if (reset) begin
      prod_reg <= 8'd0;
      acc_reg  <= 8'd0;
    end else begin
      prod_reg <= prod_full[7:0];
      acc_reg  <= mac_forget ? prod_reg : acc_reg + prod_reg;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic run_dot(input string tag, input int l, input int wb, input int xb,
                         input int exp_res, input int hold);
    int k, le, rd_cnt, f_cnt, o_cnt, f_k, o_k, both;
    int bad_stable, bad_busy, rd_seen, bad_valid;
    logic [7:0] held;
    le = (l == 0) ? 1 : l;
    rd_cnt = 0; f_cnt = 0; o_cnt = 0; f_k = 0; o_k = 0; both = 0;
    @(negedge clk);
    start = 1'b1; len = 4'(l); w_base = 6'(wb); x_base = 6'(xb);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    check({tag, "_busy"}, busy, 1);
    while (!result_valid && k < 40) begin
      if (rd_en) begin
        if (rd_cnt < 4) addr_log[rd_cnt] = w_addr;
        if (rd_cnt == 0) x_first = x_addr;
        rd_cnt++;
      end
      if (mac_forget) begin f_cnt++; f_k = k; end
      if (mac_oe) begin o_cnt++; o_k = k; end
      if (mac_forget && mac_oe) both++;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, le + 4);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_rd_count"}, rd_cnt, l);
    check({tag, "_forget_count"}, f_cnt, 1);
    check({tag, "_forget_t"}, f_k - 1, 2);
    check({tag, "_oe_count"}, o_cnt, 1);
    check({tag, "_oe_t"}, o_k - 1, le + 2);
    check({tag, "_forget_oe_overlap"}, both, 0);
    $display("dot %s L=%0d result=%0d latency=%0d", tag, l, result, k);

    held = result; bad_stable = 0; bad_busy = 0; rd_seen = 0; bad_valid = 0;
    for (int i = 0; i < hold; i++) begin
      start = (i % 2 == 0); len = 4'd1;
      @(negedge clk);
      if (result !== held) bad_stable++;
      if (busy !== 1'b1) bad_busy++;
      if (rd_en !== 1'b0) rd_seen++;
      if (result_valid !== 1'b1) bad_valid++;
    end
    start = 1'b0;
    if (hold > 0) begin
      check({tag, "_hold_stable"}, bad_stable, 0);
      check({tag, "_hold_busy"}, bad_busy, 0);
      check({tag, "_hold_no_reads"}, rd_seen, 0);
      check({tag, "_hold_valid"}, bad_valid, 0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_valid_drop"}, result_valid, 0);
    check({tag, "_busy_drop"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      w_mem[i] = 8'd0;
      x_mem[i] = 8'd0;
    end
    w_mem[0] = 8'd2;  w_mem[1] = 8'd3;  w_mem[2] = 8'd4;
    x_mem[0] = 8'd5;  x_mem[1] = 8'd6;  x_mem[2] = 8'd7;
    w_mem[8] = 8'd16; w_mem[9] = 8'd1;  x_mem[8] = 8'd16; x_mem[9] = 8'd1;
    for (int i = 16; i < 20; i++) begin
      w_mem[i] = 8'd15;
      x_mem[i] = 8'd15;
    end
    w_mem[24] = 8'd9; x_mem[24] = 8'd9;
    w_mem[63] = 8'd5;
    x_mem[40] = 8'd1; x_mem[41] = 8'd2; x_mem[42] = 8'd3;
    w_mem[48] = 8'd3; w_mem[49] = 8'd3; x_mem[48] = 8'd2; x_mem[49] = 8'd2;

    reset = 1'b1; start = 1'b0; len = '0; w_base = '0; x_base = '0; result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {rd_en, mac_forget, mac_oe, result_valid, busy}, 0);
    check("reset_data", {w_addr, x_addr, mac_weight, mac_in, result}, 0);
    reset = 1'b0;

    run_dot("l3_basic", 3, 0, 0, 56, 0);
    run_dot("l2_trunc", 2, 8, 8, 1, 0);
    run_dot("l4_all15", 4, 16, 16, 132, 0);
    run_dot("l0_empty", 0, 0, 0, 0, 0);
    run_dot("l1_hold", 1, 24, 24, 81, 10);

    // 5*1 + 2*2 + 3*3 with w addresses wrapping 63 -> 0 -> 1
    run_dot("wrap", 3, 63, 40, 18, 0);
    check("wrap_addr0", addr_log[0], 63);
    check("wrap_addr1", addr_log[1], 0);
    check("wrap_addr2", addr_log[2], 1);
    check("wrap_xaddr0", x_first, 40);

    @(negedge clk);
    start = 1'b1; len = 4'd5; w_base = 6'd0; x_base = 6'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ctrl", {rd_en, mac_forget, mac_oe, result_valid, busy}, 0);
    check("abort_data", {w_addr, x_addr, mac_weight, mac_in, result}, 0);
    @(negedge clk);
    check("abort_no_reads", rd_en, 0);

    run_dot("after_abort", 2, 48, 48, 12, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
